// File: rtl/ir_cmd_bus_interface.sv
// Bus-mapped command queue feeding an IR transmitter over a valid/ready link,
// with an optional timed auto-repeat of the last transferred command.
module ir_cmd_bus_interface #(
   parameter logic [7:0] BASE_ADDR     = 8'h90,
   parameter int         CMD_WIDTH     = 4,
   parameter int         FIFO_DEPTH    = 4,
   parameter int         REPEAT_CYCLES = 5_000_000
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 BUS_WE,
   input  logic [7:0]           ADDR,
   input  logic [7:0]           DATA_IN,
   output logic [7:0]           DATA_OUT,
   output logic                 DATA_OUT_EN,
   output logic                 CMD_VALID,
   output logic [CMD_WIDTH-1:0] CMD_DATA,
   input  logic                 CMD_READY
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int TMR_W = $clog2(REPEAT_CYCLES);

   localparam logic [1:0] REG_CMD    = 2'd0;
   localparam logic [1:0] REG_CTRL   = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_LAST   = 2'd3;

   logic [CMD_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr, rd_ptr;
   logic [CNT_W-1:0]     count;
   logic                 ovf, enable, repeat_en, transferred;
   logic [CMD_WIDTH-1:0] last_cmd;
   logic [TMR_W-1:0]     timer;

   logic [8:0] offset;
   logic       in_window, rd, wr;
   logic       cmd_wr, ctrl_wr, status_wr, flush;
   logic       full, empty, xfer, pop, push, overflow, timer_done, rpt_fire;
   logic [3:0] cnt_show;
   logic [7:0] last_ext, rd_data;
   logic       unused_data;

   // Nine-bit subtraction keeps addresses below BASE_ADDR from aliasing into the window.
   assign offset    = {1'b0, ADDR} - {1'b0, BASE_ADDR};
   assign in_window = (offset < 9'd4);
   assign rd        = ~BUS_WE & in_window;
   assign wr        = BUS_WE & in_window;
   assign cmd_wr    = wr & (offset[1:0] == REG_CMD);
   assign ctrl_wr   = wr & (offset[1:0] == REG_CTRL);
   assign status_wr = wr & (offset[1:0] == REG_STATUS);
   assign flush     = ctrl_wr & DATA_IN[7];
   assign unused_data = ^DATA_IN;

   assign full       = (count == CNT_W'(FIFO_DEPTH));
   assign empty      = (count == '0);
   assign xfer       = CMD_VALID & CMD_READY;
   assign pop        = enable & ~empty & (~CMD_VALID | CMD_READY) & ~flush;
   assign push       = cmd_wr & ~flush & (~full | pop);
   assign overflow   = cmd_wr & ~flush & full & ~pop;
   assign timer_done = (timer == TMR_W'(REPEAT_CYCLES - 1));
   assign rpt_fire   = enable & repeat_en & empty & transferred & timer_done & ~CMD_VALID;

   assign cnt_show = (32'(count) > 32'd15) ? 4'hF : 4'(count);

   // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      last_ext = '0;
      last_ext[CMD_WIDTH-1:0] = last_cmd;
      rd_data = 8'h00;
      case (offset[1:0])
         REG_CTRL:   rd_data = {6'b0, repeat_en, enable};
         REG_STATUS: rd_data = {cnt_show, CMD_VALID, ovf, full, empty};
         REG_LAST:   rd_data = last_ext;
         default:    rd_data = 8'h00;
      endcase
   end

   // NOTE: FIFO storage has no reset; the cleared pointers and count make stale entries unreachable.
   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= DATA_IN[CMD_WIDTH-1:0];
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         ovf         <= 1'b0;
         enable      <= 1'b0;
         repeat_en   <= 1'b0;
         transferred <= 1'b0;
         last_cmd    <= '0;
         timer       <= '0;
         CMD_VALID   <= 1'b0;
         CMD_DATA    <= '0;
         DATA_OUT    <= 8'h00;
         DATA_OUT_EN <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
         end

         // An overflow in the same cycle as a STATUS write wins.
         if (overflow)       ovf <= 1'b1;
         else if (status_wr) ovf <= 1'b0;

         if (ctrl_wr) begin
            enable    <= DATA_IN[0];
            repeat_en <= DATA_IN[1];
         end

         if (xfer) begin
            last_cmd    <= CMD_DATA;
            transferred <= 1'b1;
            timer       <= '0;
         end else if (!CMD_VALID && !timer_done) begin
            timer <= timer + TMR_W'(1);
         end

         // Queued commands outrank the repeat; a stalled offer is never disturbed.
         if (pop) begin
            CMD_VALID <= 1'b1;
            CMD_DATA  <= mem[rd_ptr];
         end else if (rpt_fire) begin
            CMD_VALID <= 1'b1;
            CMD_DATA  <= last_cmd;
         end else if (xfer) begin
            CMD_VALID <= 1'b0;
         end

         DATA_OUT_EN <= rd;
         DATA_OUT    <= rd ? rd_data : 8'h00;
      end
   end

endmodule

// File: tb/tb_ir_cmd_bus_interface.sv
// Scoreboard bench for ir_cmd_bus_interface: expected commands are queued as they
// are written and checked by a transfer monitor; register reads are checked inline.
module tb_ir_cmd_bus_interface;

   localparam logic [7:0] A_CMD    = 8'h90;
   localparam logic [7:0] A_CTRL   = 8'h91;
   localparam logic [7:0] A_STATUS = 8'h92;
   localparam logic [7:0] A_LAST   = 8'h93;

   logic       CLK = 1'b0;
   logic       RESET, BUS_WE, CMD_READY;
   logic [7:0] ADDR, DATA_IN, DATA_OUT;
   logic       DATA_OUT_EN, CMD_VALID;
   logic [3:0] CMD_DATA;

   int assertions = 0;
   int failures   = 0;
   int cyc        = 0;
   logic [3:0] exp_q[$];
   int         xfer_cyc[$];
   logic [3:0] mon_exp;

   ir_cmd_bus_interface #(
      .BASE_ADDR(8'h90), .CMD_WIDTH(4), .FIFO_DEPTH(4), .REPEAT_CYCLES(8)
   ) dut (
      .CLK(CLK), .RESET(RESET), .BUS_WE(BUS_WE), .ADDR(ADDR), .DATA_IN(DATA_IN),
      .DATA_OUT(DATA_OUT), .DATA_OUT_EN(DATA_OUT_EN), .CMD_VALID(CMD_VALID),
      .CMD_DATA(CMD_DATA), .CMD_READY(CMD_READY)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // Transfer monitor: inputs and outputs are stable at the falling edge.
   always @(negedge CLK) begin
      if (RESET === 1'b1 && CMD_VALID === 1'b1 && CMD_READY === 1'b1) begin
         xfer_cyc.push_back(cyc);
         assertions++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL xfer_unexpected: got CMD_DATA=%h, expected no transfer", CMD_DATA);
         end else begin
            mon_exp = exp_q.pop_front();
            if (CMD_DATA !== mon_exp) begin
               failures++;
               $display("FAIL xfer_data: got CMD_DATA=%h, expected %h", CMD_DATA, mon_exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
      BUS_WE = 1'b1; ADDR = a; DATA_IN = d;
      step();
      BUS_WE = 1'b0; ADDR = 8'h00; DATA_IN = 8'h00;
   endtask

   task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic en);
      BUS_WE = 1'b0; ADDR = a;
      step();
      d = DATA_OUT; en = DATA_OUT_EN;
      ADDR = 8'h00;
   endtask

   task automatic wait_drain(input int max, output bit ok);
      int n = 0;
      while (exp_q.size() != 0 && n < max) begin step(); n++; end
      ok = (exp_q.size() == 0);
   endtask

   task automatic wait_xfers(input int target, input int max, output bit ok);
      int n = 0;
      while (xfer_cyc.size() < target && n < max) begin step(); n++; end
      ok = (xfer_cyc.size() >= target);
   endtask

   task automatic wait_valid(input int max, output bit ok);
      int n = 0;
      while (CMD_VALID !== 1'b1 && n < max) begin step(); n++; end
      ok = (CMD_VALID === 1'b1);
   endtask

   task automatic test_reset();
      logic [7:0] d; logic en;
      RESET = 1'b1; BUS_WE = 1'b0; ADDR = 8'h00; DATA_IN = 8'h00; CMD_READY = 1'b0;
      #2 RESET = 1'b0;
      #1;
      assertions++;
      if ({CMD_VALID, CMD_DATA, DATA_OUT_EN, DATA_OUT} !== 14'h0) begin
         failures++;
         $display("FAIL reset_outputs: got valid=%b data=%h en=%b out=%h, expected all 0",
                  CMD_VALID, CMD_DATA, DATA_OUT_EN, DATA_OUT);
      end
      step(); step();
      RESET = 1'b1;
      bus_read(A_STATUS, d, en); assertions++;
      if ({en, d} !== 9'h101) begin failures++; $display("FAIL reset_status: got en=%b data=%h, expected en=1 data=01", en, d); end
      bus_read(A_CTRL, d, en); assertions++;
      if ({en, d} !== 9'h100) begin failures++; $display("FAIL reset_ctrl: got en=%b data=%h, expected en=1 data=00", en, d); end
      bus_read(A_LAST, d, en); assertions++;
      if ({en, d} !== 9'h100) begin failures++; $display("FAIL reset_last: got en=%b data=%h, expected en=1 data=00", en, d); end
      bus_read(8'h94, d, en); assertions++;
      if ({en, d} !== 9'h000) begin failures++; $display("FAIL read_above_window: got en=%b data=%h, expected en=0 data=00", en, d); end
      bus_read(8'h8F, d, en); assertions++;
      if ({en, d} !== 9'h000) begin failures++; $display("FAIL read_below_window: got en=%b data=%h, expected en=0 data=00", en, d); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d; logic en; bit ok, b2b;
      CMD_READY = 1'b1;
      bus_write(A_CTRL, 8'h01);
      xfer_cyc.delete();
      exp_q.push_back(4'h3); bus_write(A_CMD, 8'hF3);
      exp_q.push_back(4'h5); bus_write(A_CMD, 8'h55);
      exp_q.push_back(4'h7); bus_write(A_CMD, 8'hA7);
      wait_drain(20, ok); assertions++;
      if (!ok) begin failures++; $display("FAIL b2b_drain: got %0d pending, expected 0", exp_q.size()); end
      b2b = (xfer_cyc.size() == 3) && (xfer_cyc[1] - xfer_cyc[0] == 1) && (xfer_cyc[2] - xfer_cyc[1] == 1);
      assertions++;
      if (!b2b) begin failures++; $display("FAIL b2b_spacing: got %0d transfers not on consecutive cycles, expected 3 consecutive", xfer_cyc.size()); end
      step(); assertions++;
      if (CMD_VALID !== 1'b0) begin failures++; $display("FAIL b2b_valid_drop: got CMD_VALID=%b, expected 0", CMD_VALID); end
      bus_read(A_LAST, d, en); assertions++;
      if ({en, d} !== 9'h107) begin failures++; $display("FAIL b2b_last: got en=%b data=%h, expected en=1 data=07", en, d); end
      bus_write(A_LAST, 8'hFF);
      bus_read(A_LAST, d, en); assertions++;
      if ({en, d} !== 9'h107) begin failures++; $display("FAIL last_readonly: got data=%h, expected 07", d); end
      bus_write(A_CTRL, 8'h7E);
      bus_read(A_CTRL, d, en); assertions++;
      if ({en, d} !== 9'h102) begin failures++; $display("FAIL ctrl_rw: got en=%b data=%h, expected en=1 data=02", en, d); end
      bus_write(A_CTRL, 8'h00);
   endtask

   task automatic test_overflow();
      logic [7:0] d; logic en; bit ok;
      CMD_READY = 1'b0;
      bus_write(A_CTRL, 8'h00);
      for (int i = 1; i <= 5; i++) bus_write(A_CMD, 8'(i));
      bus_read(A_STATUS, d, en); assertions++;
      if ({en, d} !== 9'h146) begin failures++; $display("FAIL ovf_status: got en=%b data=%h, expected en=1 data=46", en, d); end
      bus_write(A_STATUS, 8'h00);
      bus_read(A_STATUS, d, en); assertions++;
      if ({en, d} !== 9'h142) begin failures++; $display("FAIL ovf_clear: got en=%b data=%h, expected en=1 data=42", en, d); end
      for (int i = 1; i <= 4; i++) exp_q.push_back(4'(i));
      CMD_READY = 1'b1;
      bus_write(A_CTRL, 8'h01);
      wait_drain(20, ok); assertions++;
      if (!ok) begin failures++; $display("FAIL ovf_drain: got %0d pending, expected 0", exp_q.size()); end
      bus_read(A_STATUS, d, en); assertions++;
      if ({en, d} !== 9'h101) begin failures++; $display("FAIL ovf_empty: got en=%b data=%h, expected en=1 data=01", en, d); end
      bus_read(A_LAST, d, en); assertions++;
      if ({en, d} !== 9'h104) begin failures++; $display("FAIL ovf_last: got en=%b data=%h, expected en=1 data=04", en, d); end
   endtask

   task automatic test_stall();
      logic [7:0] d; logic en; bit ok, stable;
      CMD_READY = 1'b0;
      bus_write(A_CTRL, 8'h01);
      exp_q.push_back(4'h9);
      bus_write(A_CMD, 8'h09);
      wait_valid(10, ok); assertions++;
      if (!ok) begin failures++; $display("FAIL stall_valid: got CMD_VALID=%b, expected 1", CMD_VALID); end
      bus_write(A_CTRL, 8'h00);
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (CMD_VALID !== 1'b1 || CMD_DATA !== 4'h9) stable = 1'b0;
      end
      assertions++;
      if (!stable) begin failures++; $display("FAIL stall_hold: got valid=%b data=%h, expected valid=1 data=9 held", CMD_VALID, CMD_DATA); end
      bus_read(A_STATUS, d, en); assertions++;
      if ({en, d} !== 9'h109) begin failures++; $display("FAIL stall_status: got en=%b data=%h, expected en=1 data=09", en, d); end
      CMD_READY = 1'b1;
      step(); assertions++;
      if (CMD_VALID !== 1'b0 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL stall_release: got valid=%b pending=%0d, expected valid=0 pending=0", CMD_VALID, exp_q.size());
      end
   endtask

   task automatic test_full_push_pop();
      logic [7:0] d; logic en; bit ok;
      CMD_READY = 1'b0;
      bus_write(A_CMD, 8'h0B); bus_write(A_CMD, 8'h0C);
      bus_write(A_CMD, 8'h0D); bus_write(A_CMD, 8'h0E);
      bus_read(A_STATUS, d, en); assertions++;
      if ({en, d} !== 9'h142) begin failures++; $display("FAIL full_status: got en=%b data=%h, expected en=1 data=42", en, d); end
      bus_write(A_CTRL, 8'h01);
      bus_write(A_CMD, 8'h01);
      bus_read(A_STATUS, d, en); assertions++;
      if ({en, d} !== 9'h14A) begin failures++; $display("FAIL full_push_pop: got en=%b data=%h, expected en=1 data=4a", en, d); end
      bus_write(A_CTRL, 8'h80);
      exp_q.delete();
      exp_q.push_back(4'hB);
      bus_read(A_CTRL, d, en); assertions++;
      if ({en, d} !== 9'h100) begin failures++; $display("FAIL flush_selfclear: got en=%b data=%h, expected en=1 data=00", en, d); end
      bus_read(A_STATUS, d, en); assertions++;
      if ({en, d} !== 9'h109) begin failures++; $display("FAIL flush_inflight: got en=%b data=%h, expected en=1 data=09", en, d); end
      CMD_READY = 1'b1;
      wait_drain(10, ok); assertions++;
      if (!ok) begin failures++; $display("FAIL flush_drain: got %0d pending, expected 0", exp_q.size()); end
      step();
      bus_read(A_STATUS, d, en); assertions++;
      if ({en, d} !== 9'h101) begin failures++; $display("FAIL flush_status: got en=%b data=%h, expected en=1 data=01", en, d); end
   endtask

   task automatic test_repeat();
      logic [7:0] d; logic en; bit ok, spaced;
      CMD_READY = 1'b1;
      bus_write(A_CMD, 8'h0A);
      exp_q.push_back(4'hA); exp_q.push_back(4'hA); exp_q.push_back(4'hA);
      xfer_cyc.delete();
      bus_write(A_CTRL, 8'h03);
      wait_xfers(3, 40, ok); assertions++;
      if (!ok) begin failures++; $display("FAIL repeat_count: got %0d transfers, expected 3", xfer_cyc.size()); end
      // The push lands one edge before the repeat would fire.
      repeat (6) step();
      exp_q.push_back(4'h2);
      bus_write(A_CMD, 8'h02);
      exp_q.push_back(4'h2);
      wait_xfers(5, 30, ok); assertions++;
      if (!ok) begin failures++; $display("FAIL repeat_preempt: got %0d transfers, expected 5", xfer_cyc.size()); end
      bus_write(A_CTRL, 8'h00);
      repeat (12) step();
      assertions++;
      if (xfer_cyc.size() != 5 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL repeat_stop: got %0d transfers %0d pending, expected 5 and 0", xfer_cyc.size(), exp_q.size());
      end
      spaced = 1'b1;
      for (int i = 1; i < 5; i++) if (xfer_cyc[i] - xfer_cyc[i-1] != 9) spaced = 1'b0;
      assertions++;
      if (!spaced) begin failures++; $display("FAIL repeat_interval: got transfers not 9 cycles apart, expected 9"); end
      bus_read(A_LAST, d, en); assertions++;
      if ({en, d} !== 9'h102) begin failures++; $display("FAIL repeat_last: got en=%b data=%h, expected en=1 data=02", en, d); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d; logic en; bit ok;
      CMD_READY = 1'b0;
      bus_write(A_CTRL, 8'h01);
      bus_write(A_CMD, 8'h06);
      wait_valid(10, ok); assertions++;
      if (!ok) begin failures++; $display("FAIL midrst_valid: got CMD_VALID=%b, expected 1", CMD_VALID); end
      bus_read(A_STATUS, d, en); assertions++;
      if ({en, d} !== 9'h109) begin failures++; $display("FAIL midrst_pre_status: got en=%b data=%h, expected en=1 data=09", en, d); end
      #1 RESET = 1'b0;
      #1;
      assertions++;
      if ({CMD_VALID, CMD_DATA, DATA_OUT_EN, DATA_OUT} !== 14'h0) begin
         failures++;
         $display("FAIL midrst_async: got valid=%b data=%h en=%b out=%h, expected all 0",
                  CMD_VALID, CMD_DATA, DATA_OUT_EN, DATA_OUT);
      end
      step();
      RESET = 1'b1;
      xfer_cyc.delete();
      CMD_READY = 1'b1;
      bus_read(A_STATUS, d, en); assertions++;
      if ({en, d} !== 9'h101) begin failures++; $display("FAIL midrst_status: got en=%b data=%h, expected en=1 data=01", en, d); end
      bus_read(A_CTRL, d, en); assertions++;
      if ({en, d} !== 9'h100) begin failures++; $display("FAIL midrst_ctrl: got en=%b data=%h, expected en=1 data=00", en, d); end
      bus_read(A_LAST, d, en); assertions++;
      if ({en, d} !== 9'h100) begin failures++; $display("FAIL midrst_last: got en=%b data=%h, expected en=1 data=00", en, d); end
      bus_write(A_CTRL, 8'h03);
      repeat (12) step();
      assertions++;
      if (xfer_cyc.size() != 0 || CMD_VALID !== 1'b0) begin
         failures++;
         $display("FAIL midrst_no_repeat: got %0d transfers valid=%b, expected 0 and 0", xfer_cyc.size(), CMD_VALID);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_overflow();
      test_stall();
      test_full_push_pop();
      test_repeat();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
